// File: rtl/output_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : output_accumulator
// Brief   : Accumulates phase-shifted partial sums into a saturating result and
//           hands it to readout over a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module output_accumulator #(
    parameter int DATA_W = 32,
    parameter int PHASES = 4,
    parameter int ACC_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] partial_i,
    input  logic              partial_valid_i,
    output logic              partial_ready_o,
    output logic              shift_counter_en_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [PH_W-1:0]   r_phase;
    logic              r_mode_q;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_overflow;

    logic              w_accept;
    logic              w_last;
    logic              w_start_new;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  w_sat;

    assign partial_ready_o    = (r_state == S_ACCUM);
    assign w_accept           = partial_valid_i & partial_ready_o;
    assign shift_counter_en_o = w_accept & r_mode_q;
    assign busy_o             = (r_state != S_IDLE);
    assign result_o           = r_result;
    assign result_valid_o     = r_result_valid;
    assign overflow_o         = r_overflow;

    // Carry out of the widened add means the true sum exceeds ACC_W bits.
    assign w_sum  = {1'b0, r_acc} + {1'b0, partial_i};
    assign w_sat  = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_last = ~r_mode_q | (r_phase == PH_W'(PHASES - 1));

    // A new result may begin from IDLE, or directly out of the HOLD handshake.
    assign w_start_new = start_i &
                         ((r_state == S_IDLE) | ((r_state == S_HOLD) & result_ready_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_phase        <= '0;
            r_mode_q       <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_new) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sat;
                        if (w_sum[ACC_W]) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_last) begin
                            r_phase        <= '0;
                            r_result       <= w_sat;
                            r_result_valid <= 1'b1;
                            r_state        <= S_HOLD;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (result_ready_i) begin
                        r_result_valid <= 1'b0;
                        r_state        <= w_start_new ? S_ACCUM : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_start_new) begin
                r_acc      <= '0;
                r_phase    <= '0;
                r_overflow <= 1'b0;
                r_mode_q   <= mode_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_accumulator
// Brief   : Randomized self-checking bench; expected results come from plain
//           wide-integer sums clamped to the accumulator range.
// Revision: 1.0 - initial release
// ============================================================================
module tb_output_accumulator;

    localparam int DATA_W = 32;
    localparam int PHASES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic [DATA_W-1:0] partial;
    logic              partial_valid;
    logic              partial_ready;
    logic              shift_en;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              result_ready;
    logic              busy;
    logic              overflow;

    int                n_vec = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] p [PHASES];

    always #5 clk = ~clk;

    output_accumulator #(
        .DATA_W(DATA_W),
        .PHASES(PHASES),
        .ACC_W (DATA_W)
    ) u_dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .mode_i            (mode),
        .partial_i         (partial),
        .partial_valid_i   (partial_valid),
        .partial_ready_o   (partial_ready),
        .shift_counter_en_o(shift_en),
        .result_o          (result),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .busy_o            (busy),
        .overflow_o        (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int k = 0; k < PHASES; k++) begin
            p[k] = ($urandom_range(0, 1) == 1) ? $urandom : DATA_W'($urandom_range(0, 4095));
        end
    endtask

    // One complete result: optional start, partials with random gaps, HOLD stall,
    // handshake, optionally chaining straight into the next result.
    task automatic do_result(input bit m, input bit started, input int stall,
                             input bit chain, input bit chain_mode, input int max_gap);
        longint unsigned   sum;
        logic [DATA_W-1:0] exp;
        logic              ovf;
        int                n;
        int                gaps;
        sum = 0;
        n   = m ? PHASES : 1;
        if (!started) begin
            partial_valid = 1'b1;
            partial       = $urandom;
            #1;
            check("idle_sce", 32'(shift_en), 0);
            check("idle_ready", 32'(partial_ready), 0);
            check("idle_busy", 32'(busy), 0);
            partial_valid = 1'b0;
            start         = 1'b1;
            mode          = m;
            step();
            start = 1'b0;
        end
        check("accum_busy", 32'(busy), 1);
        check("accum_ready", 32'(partial_ready), 1);
        check("accum_rvalid", 32'(result_valid), 0);
        check("start_ovf_clear", 32'(overflow), 0);
        for (int k = 0; k < n; k++) begin
            sum  = sum + 64'(p[k]);
            gaps = $urandom_range(0, max_gap);
            repeat (gaps) begin
                partial_valid = 1'b0;
                partial       = $urandom;
                start         = 1'($urandom);
                mode          = 1'($urandom);
                #1;
                check("gap_sce", 32'(shift_en), 0);
                step();
            end
            partial_valid = 1'b1;
            partial       = p[k];
            start         = 1'($urandom);
            mode          = 1'($urandom);
            #1;
            check("accept_sce", 32'(shift_en), 32'(m));
            check("accept_ready", 32'(partial_ready), 1);
            check("pre_last_rvalid", 32'(result_valid), 0);
            step();
        end
        partial_valid = 1'b0;
        start         = 1'b0;
        ovf = (sum > 64'hFFFF_FFFF);
        exp = ovf ? 32'hFFFF_FFFF : sum[31:0];
        check("hold_rvalid", 32'(result_valid), 1);
        check("hold_result", result, exp);
        check("hold_ovf", 32'(overflow), 32'(ovf));
        check("hold_ready", 32'(partial_ready), 0);
        check("hold_busy", 32'(busy), 1);
        repeat (stall) begin
            result_ready  = 1'b0;
            partial_valid = 1'($urandom);
            partial       = $urandom;
            #1;
            check("stall_sce", 32'(shift_en), 0);
            check("stall_ready", 32'(partial_ready), 0);
            step();
            check("stall_result", result, exp);
            check("stall_rvalid", 32'(result_valid), 1);
        end
        partial_valid = 1'b0;
        result_ready  = 1'b1;
        start         = chain;
        mode          = chain_mode;
        step();
        result_ready = 1'b0;
        start        = 1'b0;
        check("hs_rvalid", 32'(result_valid), 0);
        check("hs_result_kept", result, exp);
        check("hs_busy", 32'(busy), 32'(chain));
        check("hs_ready", 32'(partial_ready), 32'(chain));
    endtask

    task automatic reset_mid_accum();
        fill_random();
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            partial_valid = 1'b1;
            partial       = p[k];
            step();
        end
        rst           = 1'b1;
        partial_valid = 1'b1;
        step();
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_rvalid", 32'(result_valid), 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_ovf", 32'(overflow), 0);
        check("rst_mid_ready", 32'(partial_ready), 0);
        rst           = 1'b0;
        partial_valid = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 0);
    endtask

    initial begin
        bit started;
        bit m;
        bit ch;
        bit nm;
        rst           = 1'b1;
        start         = 1'b0;
        mode          = 1'b0;
        partial       = '0;
        partial_valid = 1'b0;
        result_ready  = 1'b0;
        repeat (2) step();
        check("rst_result", result, 0);
        check("rst_rvalid", 32'(result_valid), 0);
        check("rst_ready", 32'(partial_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        step();

        p[0] = 32'h10; p[1] = 32'h40; p[2] = 32'h100; p[3] = 32'h400;
        do_result(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);

        fill_random();
        do_result(1'b1, 1'b0, 3, 1'b0, 1'b0, 2);

        p[0] = 32'h2A3;
        do_result(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);

        p[0] = 32'hFFFF_FFF0; p[1] = 32'h20; p[2] = 32'h0; p[3] = 32'h0;
        do_result(1'b1, 1'b0, 1, 1'b0, 1'b0, 0);
        check("ovf_sticky_idle", 32'(overflow), 1);
        p[0] = 32'h5;
        do_result(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);

        fill_random();
        do_result(1'b1, 1'b0, 0, 1'b1, 1'b1, 1);
        fill_random();
        do_result(1'b1, 1'b1, 0, 1'b0, 1'b0, 1);

        reset_mid_accum();

        started = 1'b0;
        m       = 1'($urandom);
        for (int i = 0; i < 40; i++) begin
            fill_random();
            ch = 1'($urandom);
            nm = 1'($urandom);
            do_result(m, started, $urandom_range(0, 3), ch, nm, 2);
            started = ch;
            m       = nm;
        end
        if (started) begin
            fill_random();
            do_result(m, 1'b1, 0, 1'b0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
